// File: rtl/lcd_refresh_sequencer.sv
// HD44780 16x2 character LCD driver, 4-bit write-only mode: power-up init,
// then full two-row rewrites on request with one-deep request coalescing.
module lcd_refresh_sequencer #(
  parameter int PWRUP_CYCLES     = 750000,
  parameter int E_PULSE_CYCLES   = 12,
  parameter int INIT_WAIT_CYCLES = 205000,
  parameter int CMD_WAIT_CYCLES  = 2000,
  parameter int CLR_WAIT_CYCLES  = 82000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] first_line,
  input  logic [127:0] second_line,
  input  logic         update,
  output logic         init_done,
  output logic         busy,
  output logic         frame_done,
  output logic         lcd_rs,
  output logic         lcd_rw,
  output logic         lcd_e,
  output logic         lcd4,
  output logic         lcd5,
  output logic         lcd6,
  output logic         lcd7
);

  localparam int MAX_AB  = (PWRUP_CYCLES > INIT_WAIT_CYCLES) ? PWRUP_CYCLES : INIT_WAIT_CYCLES;
  localparam int MAX_CD  = (CMD_WAIT_CYCLES > CLR_WAIT_CYCLES) ? CMD_WAIT_CYCLES : CLR_WAIT_CYCLES;
  localparam int MAX_W   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int MAX_ALL = (MAX_W > E_PULSE_CYCLES) ? MAX_W : E_PULSE_CYCLES;
  localparam int CW      = $clog2(MAX_ALL + 1);

  localparam logic [CW-1:0] PWRUP_LAST = CW'(PWRUP_CYCLES - 1);
  localparam logic [CW-1:0] E_LAST     = CW'(E_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] INIT_LEN   = CW'(INIT_WAIT_CYCLES);
  localparam logic [CW-1:0] CMD_LEN    = CW'(CMD_WAIT_CYCLES);
  localparam logic [CW-1:0] CLR_LEN    = CW'(CLR_WAIT_CYCLES);

  typedef enum logic [2:0] {S_PWRUP, S_INIT_NIB, S_INIT_CMD, S_IDLE, S_FRAME} state_e;
  typedef enum logic [1:0] {P_SETUP, P_STROBE, P_HOLD, P_WAIT} phase_e;

  state_e          state_q;
  phase_e          phase_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   wait_len_q;
  logic [1:0]      step_q;
  logic            lo_q;
  logic            hdr_q;
  logic            row_q;
  logic [3:0]      char_q;
  logic            last_q;
  logic            pend_q;
  logic [127:0]    sh0_q;
  logic [127:0]    sh1_q;
  logic            init_done_q;
  logic            busy_q;
  logic            frame_done_q;
  logic            rs_q;
  logic            e_q;
  logic [3:0]      nib_q;

  logic [7:0] row0_w [16];
  logic [7:0] row1_w [16];
  logic [7:0] cmd_byte_w;
  logic [7:0] byte_w;
  logic       rs_w;
  logic [3:0] nib_w;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_cols
      assign row0_w[gi] = sh0_q[127-8*gi -: 8];
      assign row1_w[gi] = sh1_q[127-8*gi -: 8];
    end
  endgenerate

  // Byte/nibble at the sequence pointer; the pointer is advanced when a byte
  // finishes, so these already describe the next transfer during the wait.
  always_comb begin
    case (step_q)
      2'd0:    cmd_byte_w = 8'h28;
      2'd1:    cmd_byte_w = 8'h06;
      2'd2:    cmd_byte_w = 8'h0C;
      default: cmd_byte_w = 8'h01;
    endcase
    byte_w = cmd_byte_w;
    rs_w   = 1'b0;
    if (state_q == S_FRAME) begin
      if (hdr_q) begin
        byte_w = row_q ? 8'hC0 : 8'h80;
      end else begin
        byte_w = row_q ? row1_w[char_q] : row0_w[char_q];
        rs_w   = 1'b1;
      end
    end
    if (state_q == S_INIT_NIB) nib_w = (step_q == 2'd3) ? 4'h2 : 4'h3;
    else                       nib_w = byte_w[7:4];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_PWRUP;
      phase_q      <= P_SETUP;
      cnt_q        <= '0;
      wait_len_q   <= '0;
      step_q       <= 2'd0;
      lo_q         <= 1'b0;
      hdr_q        <= 1'b0;
      row_q        <= 1'b0;
      char_q       <= 4'd0;
      last_q       <= 1'b0;
      pend_q       <= 1'b0;
      sh0_q        <= '0;
      sh1_q        <= '0;
      init_done_q  <= 1'b0;
      busy_q       <= 1'b1;
      frame_done_q <= 1'b0;
      rs_q         <= 1'b0;
      e_q          <= 1'b0;
      nib_q        <= 4'h0;
    end else begin
      frame_done_q <= 1'b0;
      if (update && state_q != S_IDLE) pend_q <= 1'b1;
      case (state_q)
        S_PWRUP: begin
          if (cnt_q == PWRUP_LAST) begin
            cnt_q   <= '0;
            state_q <= S_INIT_NIB;
            phase_q <= P_SETUP;
            step_q  <= 2'd0;
            rs_q    <= 1'b0;
            nib_q   <= 4'h3;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_IDLE: begin
          if (update || pend_q) begin
            pend_q  <= 1'b0;
            sh0_q   <= first_line;
            sh1_q   <= second_line;
            state_q <= S_FRAME;
            phase_q <= P_SETUP;
            hdr_q   <= 1'b1;
            row_q   <= 1'b0;
            char_q  <= 4'd0;
            lo_q    <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b1;
            rs_q    <= 1'b0;
            nib_q   <= 4'h8;
          end else begin
            busy_q <= 1'b0;
          end
        end
        default: begin
          case (phase_q)
            P_SETUP: begin
              e_q     <= 1'b1;
              cnt_q   <= '0;
              phase_q <= P_STROBE;
            end
            P_STROBE: begin
              if (cnt_q == E_LAST) begin
                e_q     <= 1'b0;
                phase_q <= P_HOLD;
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end
            P_HOLD: begin
              if (state_q == S_INIT_NIB) begin
                wait_len_q <= INIT_LEN;
                cnt_q      <= '0;
                phase_q    <= P_WAIT;
                if (step_q == 2'd3) begin
                  state_q <= S_INIT_CMD;
                  step_q  <= 2'd0;
                end else begin
                  step_q <= step_q + 2'd1;
                end
              end else if (!lo_q) begin
                lo_q    <= 1'b1;
                phase_q <= P_SETUP;
                nib_q   <= byte_w[3:0];
              end else begin
                lo_q       <= 1'b0;
                cnt_q      <= '0;
                phase_q    <= P_WAIT;
                wait_len_q <= (!rs_w && byte_w == 8'h01) ? CLR_LEN : CMD_LEN;
                if (state_q == S_INIT_CMD) begin
                  if (step_q == 2'd3) last_q <= 1'b1;
                  else                step_q <= step_q + 2'd1;
                end else if (hdr_q) begin
                  hdr_q <= 1'b0;
                end else if (char_q == 4'd15) begin
                  char_q <= 4'd0;
                  if (row_q) begin
                    last_q <= 1'b1;
                  end else begin
                    row_q <= 1'b1;
                    hdr_q <= 1'b1;
                  end
                end else begin
                  char_q <= char_q + 4'd1;
                end
              end
            end
            default: begin
              if (cnt_q == wait_len_q - CW'(1)) begin
                if (last_q) begin
                  last_q  <= 1'b0;
                  state_q <= S_IDLE;
                  busy_q  <= pend_q | update;
                  if (state_q == S_INIT_CMD) init_done_q  <= 1'b1;
                  else                       frame_done_q <= 1'b1;
                end else begin
                  phase_q <= P_SETUP;
                  nib_q   <= nib_w;
                  rs_q    <= rs_w;
                end
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end
          endcase
        end
      endcase
    end
  end

  assign init_done  = init_done_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign lcd_rs     = rs_q;
  assign lcd_rw     = 1'b0;
  assign lcd_e      = e_q;
  assign lcd4       = nib_q[0];
  assign lcd5       = nib_q[1];
  assign lcd6       = nib_q[2];
  assign lcd7       = nib_q[3];

endmodule

// File: tb/tb_lcd_refresh_sequencer.sv
// Bench for lcd_refresh_sequencer: a schedule-queue reference model checked
// every cycle, plus decoded-strobe and timing checks for directed scenarios.
module tb_lcd_refresh_sequencer;
  localparam int PW = 20, EP = 2, IW = 8, CMW = 4, CLW = 10;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         update = 1'b0;
  logic [127:0] first_line = '0;
  logic [127:0] second_line = '0;
  logic init_done, busy, frame_done, lcd_rs, lcd_rw, lcd_e, lcd4, lcd5, lcd6, lcd7;

  lcd_refresh_sequencer #(
    .PWRUP_CYCLES(PW), .E_PULSE_CYCLES(EP), .INIT_WAIT_CYCLES(IW),
    .CMD_WAIT_CYCLES(CMW), .CLR_WAIT_CYCLES(CLW)
  ) dut (
    .clk(clk), .reset(reset), .first_line(first_line), .second_line(second_line),
    .update(update), .init_done(init_done), .busy(busy), .frame_done(frame_done),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
    .lcd4(lcd4), .lcd5(lcd5), .lcd6(lcd6), .lcd7(lcd7)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: every operation is expanded into a per-cycle list of pin values.
  typedef struct packed {logic rs; logic [3:0] d; logic e;} ent_t;
  ent_t sched[$];
  ent_t cur = '0;
  int   mode = 0;  // 0 idle, 1 init, 2 frame
  logic m_valid = 1'b0, m_init = 1'b0, m_busy = 1'b0, m_fd = 1'b0, m_pend = 1'b0;
  int   cyc = 0, rst_cyc = 0;

  function automatic void push_nib(logic rs, logic [3:0] n, int w);
    ent_t s;
    s.rs = rs; s.d = n; s.e = 1'b0;
    sched.push_back(s);
    s.e = 1'b1;
    for (int k = 0; k < EP; k++) sched.push_back(s);
    s.e = 1'b0;
    for (int k = 0; k < 1 + w; k++) sched.push_back(s);
  endfunction

  function automatic void push_byte(logic rs, logic [7:0] b);
    push_nib(rs, b[7:4], 0);
    push_nib(rs, b[3:0], (!rs && b == 8'h01) ? CLW : CMW);
  endfunction

  function automatic void build_init();
    sched.delete();
    for (int k = 0; k < PW; k++) sched.push_back('0);
    push_nib(1'b0, 4'h3, IW); push_nib(1'b0, 4'h3, IW);
    push_nib(1'b0, 4'h3, IW); push_nib(1'b0, 4'h2, IW);
    push_byte(1'b0, 8'h28); push_byte(1'b0, 8'h06);
    push_byte(1'b0, 8'h0C); push_byte(1'b0, 8'h01);
  endfunction

  function automatic void build_frame(logic [127:0] l1, logic [127:0] l2);
    sched.delete();
    push_byte(1'b0, 8'h80);
    for (int k = 0; k < 16; k++) push_byte(1'b1, l1[127-8*k -: 8]);
    push_byte(1'b0, 8'hC0);
    for (int k = 0; k < 16; k++) push_byte(1'b1, l2[127-8*k -: 8]);
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
        rst_cyc = cyc; m_valid = 1'b1; build_init(); cur = sched.pop_front();
        mode = 1; m_init = 1'b0; m_busy = 1'b1; m_fd = 1'b0; m_pend = 1'b0;
      end else if (m_valid) begin
        m_fd = 1'b0;
        if (sched.size() > 0) begin
          cur = sched.pop_front();
          if (update) m_pend = 1'b1;
        end else if (mode != 0) begin
          if (mode == 2) m_fd = 1'b1; else m_init = 1'b1;
          mode = 0;
          if (update) m_pend = 1'b1;
          m_busy = m_pend;
        end else if (update || m_pend) begin
          m_pend = 1'b0; build_frame(first_line, second_line);
          cur = sched.pop_front(); mode = 2; m_busy = 1'b1;
        end else begin
          m_busy = 1'b0;
        end
      end
    end
  end

  // Per-cycle compare plus strobe/edge monitor.
  logic [4:0] nlog[$];
  int   ncyc[$];
  int   fdone_cnt = 0, fdone_cyc = 0, busy_rise_cyc = 0, init_rise_cyc = 0, bdrop = 0;
  logic prev_e = 1'b0, prev_busy = 1'b0, prev_init = 1'b0;

  initial begin
    logic [9:0] act, exp;
    forever begin
      @(negedge clk);
      if (m_valid) begin
        act = {init_done, busy, frame_done, lcd_rs, lcd_rw, lcd_e, lcd7, lcd6, lcd5, lcd4};
        exp = {m_init, m_busy, m_fd, cur.rs, 1'b0, cur.e, cur.d};
        vectors++;
        if (act !== exp) begin
          miscompares++;
          $display("FAIL cycle_check c%0d: dut={id,busy,fd,rs,rw,e,d}=%b model=%b", cyc - rst_cyc, act, exp);
        end
      end
      if (lcd_e && !prev_e) begin nlog.push_back({lcd_rs, lcd7, lcd6, lcd5, lcd4}); ncyc.push_back(cyc); end
      if (busy && !prev_busy) busy_rise_cyc = cyc;
      if (!busy && prev_busy) bdrop++;
      if (init_done && !prev_init) init_rise_cyc = cyc;
      if (frame_done) begin fdone_cnt++; fdone_cyc = cyc; end
      prev_e = lcd_e; prev_busy = busy; prev_init = init_done;
    end
  end

  task automatic check(string nm, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end else begin
      $display("check %s ok: %0d", nm, act);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_update();
    update = 1'b1; tick(1); update = 1'b0;
  endtask

  task automatic wait_init(int budget);
    int n = 0;
    while (!init_done && n < budget) begin tick(1); n++; end
    if (!init_done) check("init_timeout", 0, 1);
  endtask

  task automatic wait_fdone(int target, int budget);
    int n = 0;
    while (fdone_cnt < target && n < budget) begin tick(1); n++; end
    if (fdone_cnt < target) check("frame_done_timeout", fdone_cnt, target);
    tick(1);
  endtask

  task automatic check_frame(string nm, logic [127:0] l1, logic [127:0] l2, int base);
    for (int i = 0; i < 34; i++) begin
      logic [8:0] ev, av;
      if (i == 0)       ev = {1'b0, 8'h80};
      else if (i < 17)  ev = {1'b1, l1[127-8*(i-1) -: 8]};
      else if (i == 17) ev = {1'b0, 8'hC0};
      else              ev = {1'b1, l2[127-8*(i-18) -: 8]};
      if (base + 2*i + 1 < nlog.size()) av = {nlog[base+2*i][4], nlog[base+2*i][3:0], nlog[base+2*i+1][3:0]};
      else                              av = ~ev;
      check($sformatf("%s_byte%0d", nm, i), int'(av), int'(ev));
    end
  endtask

  localparam logic [127:0] L1 = "WELCOME TO CSE  ";
  localparam logic [127:0] L2 = "IIT KANPUR      ";
  localparam logic [127:0] LZ = {16{8'h30}};

  initial begin
    logic [3:0] init_exp [12];
    int base, c0, b0, sz;
    init_exp = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'h6, 4'h0, 4'hC, 4'h0, 4'h1};

    // 1: init sequence
    tick(3); reset = 1'b0;
    wait_init(400);
    check("init_done_cycle", init_rise_cyc - rst_cyc, 122);
    check("init_nibble_count", nlog.size(), 12);
    check("first_strobe_cycle", (ncyc.size() > 0) ? ncyc[0] - rst_cyc : -1, 21);
    for (int i = 0; i < 12 && i < nlog.size(); i++)
      check($sformatf("init_nib%0d", i), int'(nlog[i]), int'({1'b0, init_exp[i]}));

    // 2: frame write
    first_line = L1; second_line = L2; tick(3);
    base = nlog.size(); c0 = fdone_cnt;
    pulse_update();
    wait_fdone(c0 + 1, 1000);
    check("frame_done_latency", fdone_cyc - busy_rise_cyc, 408);
    check("frame_strobes", nlog.size() - base, 68);
    check_frame("f1", L1, L2, base);

    // 3: latch isolation
    base = nlog.size(); c0 = fdone_cnt;
    pulse_update(); tick(100); first_line = LZ;
    wait_fdone(c0 + 1, 1000);
    check_frame("iso", L1, L2, base);
    base = nlog.size(); pulse_update();
    wait_fdone(c0 + 2, 1000);
    check_frame("zeros", LZ, L2, base);

    // 4: coalesced pending requests
    tick(5); base = nlog.size(); c0 = fdone_cnt; b0 = bdrop;
    pulse_update(); tick(50); pulse_update(); tick(50); pulse_update(); tick(50); pulse_update();
    wait_fdone(c0 + 2, 2000); tick(20);
    check("pend_frames", fdone_cnt - c0, 2);
    check("pend_busy_drops", bdrop - b0, 1);
    check_frame("pend_b", LZ, L2, base + 68);

    // 5: request during power-up
    reset = 1'b1; tick(1); reset = 1'b0; tick(10);
    c0 = fdone_cnt; pulse_update();
    wait_fdone(c0 + 1, 1000);
    sz = nlog.size();
    check("early_frame_start", (sz >= 68) ? ncyc[sz-68] - init_rise_cyc : -1, 2);
    check_frame("early", LZ, L2, sz - 68);

    // 6: reset at row 0 character 7
    tick(5); base = nlog.size();
    pulse_update();
    for (int n = 0; n < 500 && nlog.size() < base + 17; n++) tick(1);
    reset = 1'b1; tick(1);
    check("rst_busy", busy, 1);
    check("rst_pins", {init_done, frame_done, lcd_rs, lcd_rw, lcd_e, lcd7, lcd6, lcd5, lcd4}, 0);
    reset = 1'b0; c0 = fdone_cnt;
    wait_init(400);
    sz = nlog.size(); tick(100);
    check("no_frame_strobes", nlog.size() - sz, 0);
    check("no_frame_done", fdone_cnt - c0, 0);

    // 7: randomized traffic against the model
    for (int n = 0; n < 5000; n++) begin
      update = ($urandom_range(0, 39) == 0);
      reset  = ($urandom_range(0, 2499) == 0);
      if ($urandom_range(0, 149) == 0) first_line  = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 149) == 0) second_line = {$urandom, $urandom, $urandom, $urandom};
      tick(1);
    end
    update = 1'b0; reset = 1'b0;
    tick(1500);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/lcd_refresh_sequencer.md
Name: lcd_refresh_sequencer

Overview:
Sequences a 16x2 HD44780-compatible character LCD in 4-bit write-only mode. Runs the power-up initialisation, then writes two 128-bit ASCII line buffers to the display whenever a refresh is requested. It sits between the display-formatting logic, which builds first_line/second_line, and the LCD pins. It owns all of lcd_rs, lcd_rw, lcd_e and lcd4..lcd7.

Parameters:
PWRUP_CYCLES, 750000, idle cycles after reset before the first init nibble (15 ms at 50 MHz)
E_PULSE_CYCLES, 12, cycles lcd_e is held high per nibble
INIT_WAIT_CYCLES, 205000, wait after each of the 4 init nibbles
CMD_WAIT_CYCLES, 2000, wait after every byte except clear
CLR_WAIT_CYCLES, 82000, wait after clear-display byte 0x01

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
first_line  input  128  top row; [127:120] is column 0, [7:0] is column 15
second_line  input  128  bottom row, same packing
update  input  1  single-cycle refresh request
init_done  output  1  high once the init sequence has completed
busy  output  1  high while init or a frame write is in progress
frame_done  output  1  one-cycle pulse when a frame write completes
lcd_rs  output  1  register select (0 = command, 1 = data)
lcd_rw  output  1  read/write; tied to 0
lcd_e  output  1  enable strobe
lcd4, lcd5, lcd6, lcd7  output  1 each  data nibble bits 0..3

Behaviour:
- Reset (sampled on posedge clk) overrides everything and takes effect at the next edge.
  - All outputs go to 0, except busy=1.
  - FSM goes to PWRUP; pending flag clears.
  - Reset mid-frame or mid-init abandons the operation and restarts from PWRUP.
- lcd_rw is 0 at all times.
- Nibble transfer, 2+E_PULSE_CYCLES cycles:
  - SETUP: 1 cycle, lcd_e=0, rs and data valid.
  - STROBE: E_PULSE_CYCLES cycles, lcd_e=1.
  - HOLD: 1 cycle, lcd_e=0, rs and data unchanged.
  - rs and data change only in the SETUP cycle.
- Byte transfer:
  - High nibble, then low nibble, back to back.
  - Then a wait of CMD_WAIT_CYCLES, or CLR_WAIT_CYCLES when rs=0 and byte=0x01.
  - During waits lcd_e=0; rs and data hold their last value.
- FSM states: PWRUP -> INIT_NIB -> INIT_CMD -> IDLE -> FRAME -> IDLE.
- PWRUP:
  - Count PWRUP_CYCLES, then enter INIT_NIB.
- INIT_NIB:
  - Send single nibbles 0x3, 0x3, 0x3, 0x2 with rs=0.
  - Each nibble is followed by INIT_WAIT_CYCLES.
- INIT_CMD:
  - Send bytes 0x28, 0x06, 0x0C, 0x01 with rs=0.
  - After the clear wait: init_done=1 (stays 1 until reset), then IDLE.
- IDLE:
  - busy=0.
  - update=1 (or pending set) -> latch both line inputs into internal shadow registers, clear pending, enter FRAME, busy=1 from the next cycle.
- FRAME:
  - Send byte 0x80 (rs=0).
  - Send 16 bytes from the first_line shadow, column 0 first (rs=1).
  - Send byte 0xC0 (rs=0).
  - Send 16 bytes from the second_line shadow (rs=1).
  - Total 34 bytes.
  - After the last byte's wait: pulse frame_done for 1 cycle and return to IDLE.
- Input latching:
  - Shadows are loaded only on entry to FRAME.
  - Input changes during a frame do not affect the frame in flight.
- update during PWRUP/INIT/FRAME sets pending (one level deep; repeated requests coalesce).
  - Pending is served on the first IDLE cycle: enter FRAME again, busy stays 1 across the boundary.
  - frame_done still pulses between frames.
- update in the same cycle as reset is ignored.
- Character index counter: 0..15, wraps to 0 on row switch; counters are sized to cover the largest parameter.

Test Plan:
1. Init, with PWRUP=20, E_PULSE=2, INIT_WAIT=8, CMD_WAIT=4, CLR_WAIT=10: assert reset 3 cycles, release -> lcd_e stays 0 for 20 cycles. Then 12 lcd_e pulses carrying nibbles 3,3,3,2,2,8,0,6,0,C,0,1, each 2 cycles high, all with rs=0. init_done rises 10 cycles after the last HOLD; busy falls with it.
2. Frame: first_line="WELCOME TO CSE  ", second_line="IIT KANPUR      ", pulse update in IDLE -> 68 strobes. Decoded bytes are 0x80, 'W'(0x57)..' ', 0xC0, 'I'..' '. rs=1 only on the 32 character bytes. frame_done pulses once, 34x12 cycles after busy rises.
3. Latch isolation: change first_line to all 0x30 mid-frame -> the frame in flight still shows the original text. The next update shows "0000000000000000".
4. Pending: pulse update 3 times during a frame -> exactly one extra frame follows. frame_done pulses twice; busy never drops between the frames.
5. Early request: pulse update during PWRUP -> the frame starts on the first IDLE cycle after init_done.
6. Reset mid-frame: assert reset at character 7 of row 0 -> all outputs are 0 next cycle and busy=1. The full init sequence repeats; no frame is written without a new update.
